// File: rtl/fir_decimate.sv
// fir_decimate: decimating real FIR with a sequential one-tap-per-cycle MAC.
// Optional build macro FIR_OUT_SAT_EN saturates the written sample to signed 16-bit.
`default_nettype none

module fir_decimate #(
  parameter int NUM_TAPS   = 32,
  parameter int DECIMATION = 8,
  parameter int QUANT_BITS = 10,
  parameter logic [NUM_TAPS*32-1:0] COEFFS = '0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [31:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [31:0] out_din
);

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CNT_W = $clog2(DECIMATION + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             state;
  logic signed [31:0] x    [NUM_TAPS];
  logic signed [31:0] coef [NUM_TAPS];
  logic signed [31:0] acc;
  logic [CNT_W-1:0]   load_cnt;
  logic [TAP_W-1:0]   tap;

  logic signed [63:0] product;
  logic signed [63:0] product_deq;
  logic signed [31:0] mac_term;
  logic signed [31:0] result;

  generate
    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_coef
      assign coef[g] = COEFFS[32*g +: 32];
    end
  endgenerate

  // Full-width signed product, floor-shifted, then wrapped to 32 bits.
  assign product     = coef[tap] * x[tap];
  assign product_deq = product >>> QUANT_BITS;
  assign mac_term    = product_deq[31:0];

`ifdef FIR_OUT_SAT_EN
  always_comb begin
    result = acc;
    if (acc > 32'sd32767)
      result = 32'sd32767;
    else if (acc < -32'sd32768)
      result = -32'sd32768;
  end
`else
  assign result = acc;
`endif

  assign in_rd_en  = !reset && (state == S_LOAD) && !in_empty;
  assign out_wr_en = !reset && (state == S_WRITE) && !out_full;
  assign out_din   = out_wr_en ? result : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_LOAD;
      acc      <= '0;
      load_cnt <= '0;
      tap      <= '0;
      for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (!in_empty) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0] <= in_dout;
            if (load_cnt == CNT_W'(DECIMATION - 1)) begin
              load_cnt <= '0;
              acc      <= '0;
              tap      <= '0;
              state    <= S_MAC;
            end else begin
              load_cnt <= load_cnt + CNT_W'(1);
            end
          end
        end
        S_MAC: begin
          acc <= acc + mac_term;
          if (tap == TAP_W'(NUM_TAPS - 1))
            state <= S_WRITE;
          else
            tap <= tap + TAP_W'(1);
        end
        S_WRITE: begin
          if (!out_full) state <= S_LOAD;
        end
        default: begin
          state    <= S_LOAD;
          acc      <= '0;
          load_cnt <= '0;
          tap      <= '0;
          for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
